axis_fifo_rr_arbiter: RTL and testbench
=======================================

Name: axis_fifo_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the AXI4-Stream slave input of the AXIS FIFO between NUM_SRC upstream requesters.
- Grants one source at a time and holds the grant until that source's tlast beat is accepted.
- Forwards beats through a single-entry registered output stage and tags each beat with the source index on tid.
- Sits directly in front of the FIFO under test; its master port drives the FIFO slave port.

Parameters:
- NUM_SRC, 4, number of slave requesters (2..8).
- DATA_WIDTH, 32, tdata width in bits (multiple of 8).
- ID_WIDTH, 2, tid width; must be >= clog2(NUM_SRC).

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- arb_en  in  1  1 = new grants allowed; 0 = finish current packet, then hold idle.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready.
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_SRC*DATA_WIDTH/8  per-source byte enables.
- s_axis_tlast  in  NUM_SRC  per-source end of packet.
- m_axis_tvalid  out  1  output valid (registered).
- m_axis_tready  in  1  FIFO ready.
- m_axis_tdata  out  DATA_WIDTH  registered data.
- m_axis_tkeep  out  DATA_WIDTH/8  registered byte enables.
- m_axis_tlast  out  1  registered last.
- m_axis_tid  out  ID_WIDTH  index of the source that produced the beat.
- busy  out  1  1 while a grant is held.
- grant_id  out  ID_WIDTH  current or most recent granted source.
- pkt_count  out  16  packets forwarded; counts output beats with tlast accepted by the sink; wraps 0xFFFF->0.

Behaviour:
- Reset (aresetn low, asynchronous):
  - All outputs 0.
  - last_grant = NUM_SRC-1, so source 0 has first priority.
  - State IDLE; output register emptied. Any in-flight packet is discarded.
- States:
  - IDLE: if arb_en=1 and any s_axis_tvalid=1, select the first requester scanning from last_grant+1 modulo NUM_SRC; register it as grant; go to LOCK. Otherwise stay.
  - LOCK: pass beats from the granted source. On acceptance of its tlast beat: last_grant <= grant, go to IDLE.
- Arbitration latency: 1 cycle from tvalid seen in IDLE to tready possible. One idle cycle between consecutive packets is required.
- Ready and acceptance:
  - s_axis_tready[g] = (state==LOCK) && (!m_axis_tvalid || m_axis_tready) for the granted g.
  - All non-granted tready = 0 at all times.
  - Accepted beat (tvalid&tready) loads the output register next cycle with m_axis_tvalid=1 and m_axis_tid=g.
- Output register:
  - Holds its contents stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS stability rule).
  - Simultaneous drain and load in the same cycle gives full throughput of 1 beat/cycle within a packet.
  - Clears m_axis_tvalid when drained with no new load.
- Grant lock:
  - Grant never changes mid-packet, even if the granted source deasserts tvalid.
  - A deasserted tvalid inserts bubbles; no timeout.
- arb_en:
  - Sampled only in IDLE.
  - Deassertion during LOCK does not truncate the packet.
- busy = (state==LOCK). grant_id updates on entry to LOCK and holds after release.
- pkt_count increments on m_axis_tvalid & m_axis_tready & m_axis_tlast.
- Single-beat packet (tvalid with tlast on the first beat): LOCK lasts exactly one accepted beat.
- Wrap-around:
  - Round-robin pointer wraps NUM_SRC-1 -> 0.
  - With only one source requesting, that source is re-granted after each packet, with one idle cycle between packets.

Test Plan:
- Reset, then source 0 sends a 4-beat packet (data 0x10..0x13) with m_axis_tready=1 -> first tready 1 cycle after tvalid; output beats 0x10..0x13, tid=0, tlast on 0x13; pkt_count=1.
- Sources 0..3 all hold 2-beat packets from the same cycle -> grant order 0,1,2,3,0; tid sequence matches; no beat interleaving; one idle cycle between packets.
- Backpressure: m_axis_tready toggles 1,0,0,1 during an 8-beat packet from source 2 -> m_axis_tdata/tvalid stable while stalled; all 8 beats delivered in order, none duplicated.
- arb_en drops mid-packet of source 1 -> packet completes through tlast; no new grant while arb_en=0 despite pending tvalid on source 3; grant to 3 one cycle after arb_en returns to 1.
- aresetn asserted asynchronously at beat 2 of a 5-beat packet -> m_axis_tvalid=0, busy=0, pkt_count=0 immediately; after release, source 0 has first priority.
- pkt_count at 0xFFFF, then one more packet -> pkt_count=0x0000.

Source files
------------

// File: rtl/axis_fifo_rr_arbiter_if.sv
// Bus bundle around the arbiter: NUM_SRC AXI4-Stream requesters on the
// s_axis_* side, one AXI4-Stream port towards the FIFO on the m_axis_* side.
//   master : arbiter view (sinks the requesters, sources the FIFO port)
//   slave  : environment view (drives the requesters, sinks the FIFO port)
// s_axis_tdata/tkeep are packed per source, so source i sits at
// bits [i*DATA_WIDTH +: DATA_WIDTH] of the flattened vector.
interface axis_fifo_rr_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_SRC-1:0]                     s_axis_tvalid;
    logic [NUM_SRC-1:0]                     s_axis_tready;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     s_axis_tdata;
    logic [NUM_SRC-1:0][DATA_WIDTH/8-1:0]   s_axis_tkeep;
    logic [NUM_SRC-1:0]                     s_axis_tlast;

    logic                                   m_axis_tvalid;
    logic                                   m_axis_tready;
    logic [DATA_WIDTH-1:0]                  m_axis_tdata;
    logic [DATA_WIDTH/8-1:0]                m_axis_tkeep;
    logic                                   m_axis_tlast;
    logic [ID_WIDTH-1:0]                    m_axis_tid;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
               m_axis_tid
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
               m_axis_tid
    );
endinterface

// File: rtl/axis_fifo_rr_arbiter.sv
// Packet-granular round-robin arbiter in front of the AXIS FIFO.
// One requester is granted at a time and keeps the grant until its tlast
// beat is accepted; beats pass through a single registered output stage
// and are tagged with the source index on m_axis_tid.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   arb_en        : allow new grants (sampled only while idle)
//   axis          : requester bundle + FIFO-facing stream (master modport)
//   busy          : a grant is held
//   grant_id      : current / most recent granted source
//   pkt_count     : tlast beats accepted by the sink, wraps at 16 bits
module axis_fifo_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   arb_en,
    axis_fifo_rr_arbiter_if.master axis,
    output logic                   busy,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic [15:0]            pkt_count
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] grant;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] pick;
    logic                pick_vld;
    logic [SW-1:0]       gsel;
    logic                out_free;
    logic                take;
    logic                drain;
    logic [15:0]         pkt_cnt_q;

    assign gsel      = grant[SW-1:0];
    assign grant_id  = grant;
    assign pkt_count = pkt_cnt_q;

    // Output stage can take a beat when empty or being drained this cycle.
    assign out_free = !axis.m_axis_tvalid || axis.m_axis_tready;
    assign take     = (state == LOCK) && out_free && axis.s_axis_tvalid[gsel];
    assign drain    = axis.m_axis_tvalid && axis.m_axis_tready;

    // Round-robin pick: scan last_grant+1 .. last_grant+NUM_SRC. Iterating
    // downwards lets the nearest requester overwrite farther ones.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (axis.s_axis_tvalid[SW'((int'(last_grant) + k) % NUM_SRC)]) begin
                pick_vld = 1'b1;
                pick     = ID_WIDTH'((int'(last_grant) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        axis.s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            axis.s_axis_tready[i] = (state == LOCK) && out_free && (gsel == SW'(i));
        end
    end

    // Grant FSM. Reset points last_grant at the top source so source 0
    // is first in line.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(NUM_SRC - 1);
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && pick_vld) begin
                        grant <= pick;
                        busy  <= 1'b1;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (take && axis.s_axis_tlast[gsel]) begin
                        last_grant <= grant;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Single-entry output register; a load and a drain in the same cycle
    // keep one beat per cycle flowing.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axis.m_axis_tvalid <= 1'b0;
            axis.m_axis_tdata  <= '0;
            axis.m_axis_tkeep  <= '0;
            axis.m_axis_tlast  <= 1'b0;
            axis.m_axis_tid    <= '0;
        end else if (take) begin
            axis.m_axis_tvalid <= 1'b1;
            axis.m_axis_tdata  <= axis.s_axis_tdata[gsel];
            axis.m_axis_tkeep  <= axis.s_axis_tkeep[gsel];
            axis.m_axis_tlast  <= axis.s_axis_tlast[gsel];
            axis.m_axis_tid    <= grant;
        end else if (axis.m_axis_tready) begin
            axis.m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt_q <= '0;
        end else if (drain && axis.m_axis_tlast) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
// Bench for axis_fifo_rr_arbiter: randomized and directed requester traffic,
// a queue-based behavioural model compared every cycle, an end-to-end
// per-source scoreboard, and literal expectations for the directed cases.
module tb_axis_fifo_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        int            tid;
    } obeat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          arb_en = 1'b1;
    logic          busy;
    logic [IW-1:0] grant_id;
    logic [15:0]   pkt_count;

    axis_fifo_rr_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axis_fifo_rr_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .arb_en    (arb_en),
        .axis      (bus),
        .busy      (busy),
        .grant_id  (grant_id),
        .pkt_count (pkt_count)
    );

    always #5 aclk = ~aclk;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    // stimulus state
    beat_t       srcq[N][$];     // beats still to be offered per source
    beat_t       sent_log[N][$]; // beats accepted by the DUT, not yet seen at the output
    logic [N-1:0] vld;
    int          first_vld_cyc[N];
    int          first_rdy_cyc[N];
    obeat_t      olog[$];        // beats drained at the output
    int          cur_tid;

    // behavioural model
    int          m_owner;        // -1 when nobody holds the grant
    int          m_last;
    int          m_gid;
    obeat_t      m_out[$];       // content of the output stage (0 or 1 entry)
    logic [15:0] m_pcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_gid   = 0;
        m_out.delete();
        m_pcnt  = '0;
        vld     = '0;
        cur_tid = -1;
        olog.delete();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            sent_log[i].delete();
            first_vld_cyc[i] = -1;
            first_rdy_cyc[i] = -1;
        end
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = '0;
    endtask

    task automatic add_pkt(input int src, input int len, input logic [DW-1:0] base, input bit rk);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d = base + DW'(j);
            b.k = rk ? KW'($urandom) : '1;
            b.l = (j == len - 1);
            srcq[src].push_back(b);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input int pv, input logic mrdy);
        logic [N-1:0] hs;
        logic [N-1:0] exp_rdy;
        logic         dr;
        obeat_t       ob;
        obeat_t       nb;
        beat_t        sb;
        bit           lock;

        // registered outputs against the model
        chk("m_tvalid", bus.m_axis_tvalid, m_out.size() != 0);
        if (m_out.size() != 0) begin
            chk("m_tdata", bus.m_axis_tdata, m_out[0].d);
            chk("m_tkeep", bus.m_axis_tkeep, m_out[0].k);
            chk("m_tlast", bus.m_axis_tlast, m_out[0].l);
            chk("m_tid",   bus.m_axis_tid,   m_out[0].tid);
        end
        chk("busy",      busy,      m_owner >= 0);
        chk("grant_id",  grant_id,  m_gid);
        chk("pkt_count", pkt_count, m_pcnt);

        // drive requesters; an offered beat stays up until accepted
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && srcq[i].size() != 0 && $urandom_range(99) < pv) vld[i] = 1'b1;
            bus.s_axis_tvalid[i] = vld[i];
            if (vld[i]) begin
                bus.s_axis_tdata[i] = srcq[i][0].d;
                bus.s_axis_tkeep[i] = srcq[i][0].k;
                bus.s_axis_tlast[i] = srcq[i][0].l;
                if (first_vld_cyc[i] < 0) first_vld_cyc[i] = cyc;
            end else begin
                bus.s_axis_tdata[i] = '0;
                bus.s_axis_tkeep[i] = '0;
                bus.s_axis_tlast[i] = 1'b0;
            end
        end
        bus.m_axis_tready = mrdy;
        #1;

        lock    = (m_owner >= 0);
        exp_rdy = '0;
        if (lock && (m_out.size() == 0 || mrdy)) exp_rdy[m_owner] = 1'b1;
        chk("s_tready", bus.s_axis_tready, exp_rdy);
        for (int i = 0; i < N; i++)
            if (bus.s_axis_tready[i] && first_rdy_cyc[i] < 0) first_rdy_cyc[i] = cyc;

        hs     = bus.s_axis_tvalid & bus.s_axis_tready;
        dr     = bus.m_axis_tvalid && mrdy;
        ob.d   = bus.m_axis_tdata;
        ob.k   = bus.m_axis_tkeep;
        ob.l   = bus.m_axis_tlast;
        ob.tid = int'(bus.m_axis_tid);

        // model next state
        if (m_out.size() != 0 && mrdy) begin
            if (m_out[0].l) m_pcnt = m_pcnt + 16'd1;
            void'(m_out.pop_front());
        end
        if (lock) begin
            if (exp_rdy[m_owner] && vld[m_owner]) begin
                nb.d   = srcq[m_owner][0].d;
                nb.k   = srcq[m_owner][0].k;
                nb.l   = srcq[m_owner][0].l;
                nb.tid = m_owner;
                m_out.push_back(nb);
                if (nb.l) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end else if (arb_en) begin
            for (int k = 1; k <= N; k++) begin
                if (vld[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_gid   = m_owner;
                    break;
                end
            end
        end

        @(posedge aclk);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                sb = srcq[i].pop_front();
                sent_log[i].push_back(sb);
                vld[i] = 1'b0;
            end
        end
        if (dr) begin
            olog.push_back(ob);
            chk("sb_have_beat", sent_log[ob.tid].size() != 0, 1'b1);
            if (sent_log[ob.tid].size() != 0) begin
                sb = sent_log[ob.tid].pop_front();
                chk("sb_data", ob.d, sb.d);
                chk("sb_keep", ob.k, sb.k);
                chk("sb_last", ob.l, sb.l);
            end
            if (cur_tid >= 0) chk("no_interleave", ob.tid, cur_tid);
            cur_tid = ob.l ? -1 : ob.tid;
        end
        cyc++;
        @(negedge aclk);
    endtask

    function automatic bit all_idle();
        bit r = (m_owner < 0) && (m_out.size() == 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) r = 0;
        return r;
    endfunction

    // Run until every queued beat has left the output; bp selects the 1,0,0,1 sink pattern.
    task automatic drain(input int pv, input bit bp);
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n = 0;
        while (!all_idle() && n < 500) begin
            cycle(pv, bp ? pat[cyc % 4] : 1'b1);
            n++;
        end
        chk("drain_in_budget", n < 500, 1'b1);
    endtask

    task automatic reset_pulse();
        aresetn = 1'b0;
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [$];
        int exp_order [5] = '{0, 1, 2, 3, 0};

        model_reset();
        bus.m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_m_tvalid",  bus.m_axis_tvalid, 1'b0);
        chk("rst_busy",      busy, 1'b0);
        chk("rst_pkt_count", pkt_count, 16'h0);
        chk("rst_grant_id",  grant_id, 2'd0);
        chk("rst_s_tready",  bus.s_axis_tready, 4'h0);
        aresetn = 1'b1;

        // single 4-beat packet from source 0
        add_pkt(0, 4, 32'h10, 1'b0);
        drain(100, 1'b0);
        chk("t1_rdy_latency", first_rdy_cyc[0] - first_vld_cyc[0], 1);
        chk("t1_beats", olog.size(), 4);
        for (int j = 0; j < 4 && j < olog.size(); j++) begin
            chk("t1_data", olog[j].d, 32'h10 + j);
            chk("t1_tid",  olog[j].tid, 0);
            chk("t1_last", olog[j].l, j == 3);
        end
        chk("t1_pkt_count", pkt_count, 16'd1);

        // all four sources compete with 2-beat packets
        reset_pulse();
        for (int s = 0; s < N; s++) add_pkt(s, 2, 32'h100 * (s + 1), 1'b1);
        add_pkt(0, 2, 32'h500, 1'b1);
        drain(100, 1'b0);
        foreach (olog[j]) if (olog[j].l) ord.push_back(olog[j].tid);
        chk("t2_pkts", ord.size(), 5);
        for (int j = 0; j < 5 && j < ord.size(); j++) chk("t2_order", ord[j], exp_order[j]);
        chk("t2_pkt_count", pkt_count, 16'd5);

        // 8-beat packet from source 2 under backpressure
        olog.delete();
        add_pkt(2, 8, 32'h20, 1'b0);
        drain(100, 1'b1);
        chk("t3_beats", olog.size(), 8);
        for (int j = 0; j < 8 && j < olog.size(); j++) begin
            chk("t3_data", olog[j].d, 32'h20 + j);
            chk("t3_tid",  olog[j].tid, 2);
        end

        // arb_en drops during source 1's packet, source 3 waits
        olog.delete();
        add_pkt(1, 4, 32'h40, 1'b0);
        cycle(100, 1'b1);
        add_pkt(3, 1, 32'h60, 1'b0);
        cycle(100, 1'b1);
        arb_en = 1'b0;
        repeat (8) cycle(100, 1'b1);
        chk("t4_src1_done", olog.size(), 4);
        if (olog.size() == 4) chk("t4_last", olog[3].l, 1'b1);
        chk("t4_busy_held_off", busy, 1'b0);
        chk("t4_grant_id", grant_id, 2'd1);
        chk("t4_src3_pending", srcq[3].size(), 1);
        arb_en = 1'b1;
        cycle(100, 1'b1);
        chk("t4_busy_regrant", busy, 1'b1);
        chk("t4_grant_3", grant_id, 2'd3);
        drain(100, 1'b0);

        // asynchronous reset in the middle of a 5-beat packet
        add_pkt(1, 5, 32'h70, 1'b0);
        repeat (3) cycle(100, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("t5_m_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("t5_busy",     busy, 1'b0);
        chk("t5_pkt_count", pkt_count, 16'h0);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        add_pkt(3, 1, 32'h90, 1'b0);
        add_pkt(0, 1, 32'h80, 1'b0);
        cycle(100, 1'b1);
        chk("t5_busy_after", busy, 1'b1);
        chk("t5_src0_first", grant_id, 2'd0);
        drain(100, 1'b0);

        // pkt_count wrap
        force dut.pkt_cnt_q = 16'hFFFF;
        #1;
        release dut.pkt_cnt_q;
        m_pcnt = 16'hFFFF;
        @(negedge aclk);
        add_pkt(2, 2, 32'hA0, 1'b0);
        drain(100, 1'b0);
        chk("t6_wrap", pkt_count, 16'h0000);

        // randomized traffic
        reset_pulse();
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < N; s++)
                if (srcq[s].size() < 3 && $urandom_range(9) == 0)
                    add_pkt(s, $urandom_range(1, 6), DW'($urandom), 1'b1);
            arb_en = ($urandom_range(19) != 0);
            cycle(70, $urandom_range(99) < 70);
        end
        arb_en = 1'b1;
        drain(100, 1'b0);
        for (int s = 0; s < N; s++) chk("rand_all_delivered", sent_log[s].size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
